// File: rtl/trivium_pkg.sv
// Shared Trivium definitions: FSM states, tap positions (1-based, as in the
// cipher description) and the 288-bit key/IV load.
package trivium_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam int STATE_BITS = 288;
  localparam int R1_END     = 93;   // last bit of register A
  localparam int R2_END     = 177;  // last bit of register B

  localparam int T1_A     = 66;
  localparam int T1_B     = 93;
  localparam int T1_AND_A = 91;
  localparam int T1_AND_B = 92;
  localparam int T1_FB    = 171;
  localparam int T2_A     = 162;
  localparam int T2_B     = 177;
  localparam int T2_AND_A = 175;
  localparam int T2_AND_B = 176;
  localparam int T2_FB    = 264;
  localparam int T3_A     = 243;
  localparam int T3_B     = 288;
  localparam int T3_AND_A = 286;
  localparam int T3_AND_B = 287;
  localparam int T3_FB    = 69;

  // Bit k-1 of the vector holds Trivium state bit s_k.
  function automatic logic [STATE_BITS-1:0] trivium_load(input logic [79:0] key,
                                                         input logic [79:0] iv);
    logic [STATE_BITS-1:0] s;
    s          = '0;
    s[79:0]    = key;
    s[172:93]  = iv;
    s[287:285] = 3'b111;
    return s;
  endfunction

endpackage

// File: rtl/trivium_step.sv
// One combinational Trivium bit-step: keystream bit z and the shifted state.
module trivium_step
  import trivium_pkg::*;
(
  input  logic [STATE_BITS-1:0] state_in,
  output logic [STATE_BITS-1:0] state_out,
  output logic                  z
);

  logic a1, a2, a3;
  logic f1, f2, f3;

  assign a1 = state_in[T1_A-1] ^ state_in[T1_B-1];
  assign a2 = state_in[T2_A-1] ^ state_in[T2_B-1];
  assign a3 = state_in[T3_A-1] ^ state_in[T3_B-1];
  assign z  = a1 ^ a2 ^ a3;

  assign f1 = a1 ^ (state_in[T1_AND_A-1] & state_in[T1_AND_B-1]) ^ state_in[T1_FB-1];
  assign f2 = a2 ^ (state_in[T2_AND_A-1] & state_in[T2_AND_B-1]) ^ state_in[T2_FB-1];
  assign f3 = a3 ^ (state_in[T3_AND_A-1] & state_in[T3_AND_B-1]) ^ state_in[T3_FB-1];

  // f3 enters s1, f1 enters s94, f2 enters s178; the rest shifts up by one.
  assign state_out = {state_in[STATE_BITS-2:R2_END], f2,
                      state_in[R2_END-2:R1_END], f1,
                      state_in[R1_END-2:0], f3};

endmodule

// File: rtl/trivium_stream.sv
// Trivium stream cipher with valid/ready word interface, W keystream bits per cycle.
//   state | meaning
//   IDLE  | no key loaded or message finished; last output word may still drain
//   INIT  | warm-up, INIT_STEPS/W advances with keystream discarded
//   RUN   | one advance per accepted input word, output = input ^ keystream
module trivium_stream
  import trivium_pkg::*;
#(
  parameter int W          = 8,
  parameter int INIT_STEPS = 1152
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [79:0]  key,
  input  logic [79:0]  iv,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         busy
);

  localparam int INIT_CYCLES = INIT_STEPS / W;
  localparam int CNT_W       = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

  state_t                 state_q, state_d;
  logic [STATE_BITS-1:0]  s_q;
  logic [CNT_W-1:0]       init_cnt_q;
  logic [STATE_BITS-1:0]  chain [W+1];
  logic [W-1:0]           ks;
  logic                   init_done, accept, advance;

  assign chain[0] = s_q;

  for (genvar i = 0; i < W; i++) begin : g_step
    trivium_step u_step (
      .state_in (chain[i]),
      .state_out(chain[i+1]),
      .z        (ks[i])
    );
  end

  assign init_done = (init_cnt_q == '0);
  assign busy      = (state_q == INIT) || (state_q == RUN);
  assign in_ready  = (state_q == RUN) && (!out_valid || out_ready);
  // A reload wins over a word arriving on the same edge.
  assign accept    = in_valid && in_ready && !start;
  assign advance   = (state_q == INIT) || accept;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = INIT;
    end else begin
      case (state_q)
        INIT:    if (init_done) state_d = RUN;
        RUN:     if (accept && in_last) state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_q        <= '0;
      init_cnt_q <= '0;
    end else if (start) begin
      s_q        <= trivium_load(key, iv);
      init_cnt_q <= CNT_W'(INIT_CYCLES - 1);
    end else if (advance) begin
      s_q <= chain[W];
      if ((state_q == INIT) && !init_done) init_cnt_q <= init_cnt_q - CNT_W'(1);
    end
  end

  // An abort drops the pending word; in IDLE the final word keeps draining.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (start && busy) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= in_data ^ ks;
      out_last  <= in_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_trivium_stream.sv
// Scoreboard bench for trivium_stream: W=8, W=1 and W=64 instances checked
// against a bit-serial Trivium model.
module tb_trivium_stream;

  localparam int KS_BITS  = 4224;
  localparam int MSG_BITS = 4096;

  typedef struct {
    logic [63:0] data;
    logic        last;
  } exp_t;

  logic        clk;
  logic        reset, start, in_valid, in_last, out_ready;
  logic [79:0] key, iv;
  logic [63:0] in_data;

  logic       ir8, ov8, ol8, busy8;
  logic [7:0] od8;
  logic       ir1, ov1, ol1, busy1;
  logic [0:0] od1;
  logic        ir64, ov64, ol64, busy64;
  logic [63:0] od64;

  int          cur;
  int          cur_w;
  logic        cur_ir, cur_ov, cur_ol, cur_busy;
  logic [63:0] cur_od;

  exp_t        sb[$];
  logic [63:0] cap_q[$];
  exp_t        mon_e;
  bit          ks  [KS_BITS];
  bit          msg [MSG_BITS];
  int          n_tests, n_fail, word_n;

  trivium_stream #(.W(8)) u_dut8 (
    .clk(clk), .reset(reset), .start(start), .key(key), .iv(iv),
    .in_valid(in_valid), .in_ready(ir8), .in_data(in_data[7:0]), .in_last(in_last),
    .out_valid(ov8), .out_ready(out_ready), .out_data(od8), .out_last(ol8), .busy(busy8)
  );

  trivium_stream #(.W(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .key(key), .iv(iv),
    .in_valid(in_valid), .in_ready(ir1), .in_data(in_data[0:0]), .in_last(in_last),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_last(ol1), .busy(busy1)
  );

  trivium_stream #(.W(64)) u_dut64 (
    .clk(clk), .reset(reset), .start(start), .key(key), .iv(iv),
    .in_valid(in_valid), .in_ready(ir64), .in_data(in_data), .in_last(in_last),
    .out_valid(ov64), .out_ready(out_ready), .out_data(od64), .out_last(ol64), .busy(busy64)
  );

  always_comb begin
    cur_w = 8; cur_ir = ir8; cur_ov = ov8; cur_ol = ol8; cur_busy = busy8; cur_od = 64'(od8);
    if (cur == 1) begin
      cur_w = 1; cur_ir = ir1; cur_ov = ov1; cur_ol = ol1; cur_busy = busy1; cur_od = 64'(od1);
    end else if (cur == 2) begin
      cur_w = 64; cur_ir = ir64; cur_ov = ov64; cur_ol = ol64; cur_busy = busy64; cur_od = od64;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ks_word(input int n, input int w);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < w; i++) if (n * w + i < KS_BITS) r[i] = ks[n * w + i];
    return r;
  endfunction

  function automatic logic [63:0] msg_word(input int n, input int w);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < w; i++) r[i] = msg[n * w + i];
    return r;
  endfunction

  function automatic logic [63:0] wmask(input int w);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < w; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Bit-serial reference: 1152 warm-up steps, then keystream into ks[].
  task automatic model_gen(input logic [79:0] k, input logic [79:0] v);
    bit s [1:288];
    bit t1, t2, t3;
    for (int i = 1; i <= 288; i++) s[i] = 1'b0;
    for (int i = 1; i <= 80; i++) begin
      s[i]      = k[i-1];
      s[93 + i] = v[i-1];
    end
    s[286] = 1'b1; s[287] = 1'b1; s[288] = 1'b1;
    for (int n = 0; n < 1152 + KS_BITS; n++) begin
      t1 = s[66] ^ s[93];
      t2 = s[162] ^ s[177];
      t3 = s[243] ^ s[288];
      if (n >= 1152) ks[n - 1152] = t1 ^ t2 ^ t3;
      t1 = t1 ^ (s[91] & s[92]) ^ s[171];
      t2 = t2 ^ (s[175] & s[176]) ^ s[264];
      t3 = t3 ^ (s[286] & s[287]) ^ s[69];
      for (int i = 288; i > 1; i--) s[i] = s[i-1];
      s[1] = t3; s[94] = t1; s[178] = t2;
    end
  endtask

  // Handshakes resolve at the next posedge; sampling here sees their final values.
  always @(negedge clk) begin
    if (!reset && !start) begin
      if (cur_ov && out_ready) begin
        chk("sb_underflow", 64'(sb.size() == 0), 64'd0);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          chk("out_data", cur_od, mon_e.data);
          chk("out_last", 64'(cur_ol), 64'(mon_e.last));
          cap_q.push_back(cur_od);
        end
      end
      if (in_valid && cur_ir) begin
        mon_e.data = (in_data & wmask(cur_w)) ^ ks_word(word_n, cur_w);
        mon_e.last = in_last;
        sb.push_back(mon_e);
        word_n++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input logic [79:0] k, input logic [79:0] v);
    key = k; iv = v; start = 1'b1;
    model_gen(k, v);
    sb.delete();
    word_n = 0;
    tick(1);
    start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sb.delete();
    tick(1);
    chk("rst_out_valid", 64'(cur_ov), 64'd0);
    chk("rst_out_data", cur_od, 64'd0);
    chk("rst_out_last", 64'(cur_ol), 64'd0);
    chk("rst_busy", 64'(cur_busy), 64'd0);
    chk("rst_in_ready", 64'(cur_ir), 64'd0);
    reset = 1'b0;
  endtask

  task automatic send(input logic [63:0] d, input logic l);
    bit acc;
    int guard;
    acc = 1'b0; guard = 0;
    in_valid = 1'b1; in_data = d; in_last = l;
    while (!acc && guard < 2000) begin
      @(negedge clk);
      acc = cur_ir;
      @(posedge clk);
      #1;
      guard++;
    end
    if (!acc) chk("send_timeout", 64'(acc), 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid = 1'b0;
    tick(4);
    chk("sb_drained", 64'(sb.size()), 64'd0);
  endtask

  task automatic no_output_after_reset();
    int seen;
    seen = 0;
    in_valid = 1'b1; in_data = 64'hA5A5_A5A5_A5A5_A5A5;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      if (cur_ov || cur_busy || cur_ir) seen++;
    end
    in_valid = 1'b0;
    chk("idle_after_reset", 64'(seen), 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  golden [8];
    logic [63:0] ctw;
    int lat, cnt;
    golden = '{8'hFB, 8'hE0, 8'hBF, 8'h26, 8'h58, 8'h59, 8'h05, 8'h1B};
    n_tests = 0; n_fail = 0; word_n = 0; cur = 0;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    key = '0; iv = '0; in_data = '0;
    tick(3);
    reset = 1'b0;
    chk("reset_out_valid", 64'(cur_ov), 64'd0);
    chk("reset_out_data", cur_od, 64'd0);
    chk("reset_busy", 64'(cur_busy), 64'd0);
    chk("reset_in_ready", 64'(cur_ir), 64'd0);

    // Zero key/IV known-answer and start-to-first-output latency.
    cap_q.delete();
    do_start(80'h0, 80'h0);
    in_valid = 1'b1; in_data = '0; in_last = 1'b0;
    lat = 0;
    while (!cur_ov && lat < 300) begin
      tick(1);
      lat++;
    end
    chk("first_valid_latency", 64'(lat), 64'd145);
    cnt = 0;
    while (cap_q.size() < 8 && cnt < 50) begin
      tick(1);
      cnt++;
    end
    in_valid = 1'b0;
    drain();
    for (int i = 0; i < 8; i++)
      chk($sformatf("estream_byte%0d", i), (cap_q.size() > i) ? cap_q[i] : 64'hX, 64'(golden[i]));

    // Backpressure: output held, no input accepted, keystream frozen.
    cap_q.delete();
    out_ready = 1'b0;
    send(64'($urandom()), 1'b0);
    in_valid = 1'b1; in_data = 64'($urandom()); in_last = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("stall_in_ready", 64'(cur_ir), 64'd0);
      chk("stall_out_valid", 64'(cur_ov), 64'd1);
      chk("stall_out_data", cur_od, (sb.size() > 0) ? sb[0].data : 64'hX);
      tick(1);
    end
    out_ready = 1'b1;
    tick(1);
    for (int i = 0; i < 3; i++) send(64'($urandom()), 1'b0);
    drain();
    chk("stall_word_count", 64'(cap_q.size()), 64'd5);

    // Abort with a new key on word 5 of RUN.
    do_start(80'h1234_5678_9ABC_DEF0_1357, 80'hFEDC_BA98_7654_3210_2468);
    for (int i = 0; i < 5; i++) send(64'($urandom()), 1'b0);
    key = 80'h0F0F_1E1E_2D2D_3C3C_4B4B; iv = 80'h5A5A_6969_7878_8787_9696;
    start = 1'b1; in_valid = 1'b1; in_data = 64'($urandom());
    model_gen(key, iv);
    sb.delete();
    word_n = 0;
    tick(1);
    start = 1'b0; in_valid = 1'b0;
    chk("abort_out_valid", 64'(cur_ov), 64'd0);
    chk("abort_busy", 64'(cur_busy), 64'd1);
    chk("abort_in_ready", 64'(cur_ir), 64'd0);
    cap_q.delete();
    for (int i = 0; i < 3; i++) send(64'($urandom()), 1'b0);
    drain();
    chk("abort_word_count", 64'(cap_q.size()), 64'd3);

    // Reset mid-INIT and mid-RUN.
    do_start(80'hAAAA_5555_AAAA_5555_AAAA, 80'h1111_2222_3333_4444_5555);
    tick(50);
    do_reset();
    no_output_after_reset();
    do_start(80'hAAAA_5555_AAAA_5555_AAAA, 80'h1111_2222_3333_4444_5555);
    out_ready = 1'b0;
    send(64'hFF, 1'b0);
    do_reset();
    out_ready = 1'b1;
    no_output_after_reset();

    // in_last on word 3.
    cap_q.delete();
    do_start(80'h0000_0000_0000_0000_0001, 80'h8000_0000_0000_0000_0000);
    send(64'h11, 1'b0);
    send(64'h22, 1'b0);
    send(64'h33, 1'b1);
    chk("last_busy_falls", 64'(cur_busy), 64'd0);
    cnt = 0;
    in_valid = 1'b1; in_data = 64'h44; in_last = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (cur_ir) cnt++;
    end
    in_valid = 1'b0;
    chk("last_ignores_input", 64'(cnt), 64'd0);
    chk("last_word_count", 64'(cap_q.size()), 64'd3);
    chk("sb_after_last", 64'(sb.size()), 64'd0);

    // 4096-bit random message through W=1 and W=64, then decrypt at W=64.
    for (int i = 0; i < MSG_BITS; i++) msg[i] = bit'($urandom_range(1, 0));
    cur = 1;
    cap_q.delete();
    do_start(80'hC0FF_EE00_1122_3344_5566, 80'h7788_99AA_BBCC_DDEE_FF00);
    for (int j = 0; j < MSG_BITS; j++) send(msg_word(j, 1), j == MSG_BITS - 1);
    drain();
    chk("w1_word_count", 64'(cap_q.size()), 64'(MSG_BITS));

    cur = 2;
    cap_q.delete();
    do_start(80'hC0FF_EE00_1122_3344_5566, 80'h7788_99AA_BBCC_DDEE_FF00);
    for (int j = 0; j < MSG_BITS / 64; j++) send(msg_word(j, 64), j == MSG_BITS / 64 - 1);
    drain();
    chk("w64_word_count", 64'(cap_q.size()), 64'(MSG_BITS / 64));

    cap_q.delete();
    do_start(80'hC0FF_EE00_1122_3344_5566, 80'h7788_99AA_BBCC_DDEE_FF00);
    for (int j = 0; j < MSG_BITS / 64; j++) begin
      ctw = msg_word(j, 64) ^ ks_word(j, 64);
      send(ctw, j == MSG_BITS / 64 - 1);
    end
    drain();
    for (int j = 0; j < MSG_BITS / 64; j++)
      chk($sformatf("decrypt_w%0d", j), (cap_q.size() > j) ? cap_q[j] : 64'hX, msg_word(j, 64));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
